// File: rtl/mac_pipe_sat.sv
// Signed pipelined multiply with optional saturating accumulate and overflow flag.
// Latency: NUM_STAGE ce=1 cycles from an accepted sample to its out_valid.
// No backpressure: ce=0 freezes every register; one sample is accepted per ce=1 cycle.
module mac_pipe_sat #(
    parameter int A_WIDTH   = 6,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 21,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    input  logic               acc_en,
    input  logic               acc_clear,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] dout,
    output logic               dout_ovf
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH;   // exact product width
    localparam int N_PROD  = NUM_STAGE - 2;       // product pipeline depth
    localparam int S_WIDTH = ACC_WIDTH + 1;       // sum width, one guard bit

    localparam logic [S_WIDTH-1:0]   ONE_S = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic [S_WIDTH-1:0]   P_MAX = (ONE_S << (P_WIDTH - 1)) - ONE_S;
    localparam logic [S_WIDTH-1:0]   P_MIN = ~P_MAX;
    localparam logic [ACC_WIDTH-1:0] A_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] A_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Stage 1: registered inputs; controls are masked so bubbles never carry them.
    logic               s1_vld_q;
    logic               s1_acc_q;
    logic               s1_clr_q;
    logic [A_WIDTH-1:0] s1_a_q;
    logic [B_WIDTH-1:0] s1_b_q;

    // Product pipeline, one entry per stage 2..NUM_STAGE-1.
    logic [N_PROD-1:0]  pv_q;
    logic [N_PROD-1:0]  pacc_q;
    logic [N_PROD-1:0]  pclr_q;
    logic [M_WIDTH-1:0] prod_q [N_PROD];

    // Final accumulate/saturate/output stage.
    logic               vld_q;
    logic [P_WIDTH-1:0] dout_q, dout_d;
    logic               ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;

    // Sign-extended operands make the truncated multiply exact at M_WIDTH.
    logic signed [M_WIDTH-1:0] a_ext, b_ext, prod_d;
    assign a_ext  = {{B_WIDTH{s1_a_q[A_WIDTH-1]}}, s1_a_q};
    assign b_ext  = {{A_WIDTH{s1_b_q[B_WIDTH-1]}}, s1_b_q};
    assign prod_d = a_ext * b_ext;

    logic fin_vld, fin_acc, fin_clr;
    assign fin_vld = pv_q[N_PROD-1];
    assign fin_acc = pacc_q[N_PROD-1];
    assign fin_clr = pclr_q[N_PROD-1];

    // Accumulate in ACC_WIDTH+1 bits so an overflow is always visible in the guard bit.
    logic signed [S_WIDTH-1:0] prod_ext, base_ext, sum;
    logic [ACC_WIDTH-1:0]      acc_sat;
    logic                      acc_ovf;
    assign prod_ext = {{(S_WIDTH-M_WIDTH){prod_q[N_PROD-1][M_WIDTH-1]}}, prod_q[N_PROD-1]};
    assign base_ext = fin_clr ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    assign sum      = base_ext + prod_ext;
    assign acc_ovf  = sum[S_WIDTH-1] != sum[S_WIDTH-2];
    assign acc_sat  = acc_ovf ? (sum[S_WIDTH-1] ? A_MIN : A_MAX) : sum[ACC_WIDTH-1:0];

    logic signed [S_WIDTH-1:0] sat_in;
    logic                      sat_pre;
    logic                      p_hi, p_lo;

    // Final-stage next state: bubbles hold dout/ovf/accumulator, valid samples update them.
    always_comb begin
        acc_d   = acc_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        sat_in  = prod_ext;
        sat_pre = 1'b0;
        if (fin_acc) begin
            sat_in  = {acc_sat[ACC_WIDTH-1], acc_sat};
            sat_pre = acc_ovf;
        end
        p_hi = sat_in > $signed(P_MAX);
        p_lo = sat_in < $signed(P_MIN);
        if (fin_vld) begin
            if (fin_acc) begin
                acc_d = acc_sat;
            end else if (fin_clr) begin
                acc_d = '0;
            end
            if (p_hi) begin
                dout_d = P_MAX[P_WIDTH-1:0];
            end else if (p_lo) begin
                dout_d = P_MIN[P_WIDTH-1:0];
            end else begin
                dout_d = sat_in[P_WIDTH-1:0];
            end
            ovf_d = sat_pre | p_hi | p_lo;
        end
    end

    // Pipeline advance: reset wins over ce, ce=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_acc_q <= 1'b0;
            s1_clr_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            pv_q     <= '0;
            pacc_q   <= '0;
            pclr_q   <= '0;
            for (int i = 0; i < N_PROD; i++) begin
                prod_q[i] <= '0;
            end
            vld_q  <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            acc_q  <= '0;
        end else if (ce) begin
            s1_vld_q  <= in_valid;
            s1_acc_q  <= in_valid & acc_en;
            s1_clr_q  <= in_valid & acc_clear;
            s1_a_q    <= din0;
            s1_b_q    <= din1;
            pv_q[0]   <= s1_vld_q;
            pacc_q[0] <= s1_acc_q;
            pclr_q[0] <= s1_clr_q;
            prod_q[0] <= prod_d;
            for (int i = 1; i < N_PROD; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pacc_q[i] <= pacc_q[i-1];
                pclr_q[i] <= pclr_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
            vld_q  <= fin_vld;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            acc_q  <= acc_d;
        end
    end

    assign out_valid = vld_q;
    assign dout      = dout_q;
    assign dout_ovf  = ovf_q;
endmodule
